// File: rtl/report_arb.sv
// report_arb: three-source round-robin packet arbiter merging report streams
// toward the FPGA OS. A grant is held for one whole packet (head..tail) and the
// merged stream is registered with one cycle of latency.
// Optional watchdog: define REPORT_ARB_TIMEOUT_EN to terminate packets whose
// grant lasts TIMEOUT_CYCLES cycles and count them in out_rpt_timeout_cnt.
module report_arb #(
    parameter     PLATFORM       = "xilinx",
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   in_rpt_req,
    output logic [2:0]   out_rpt_gnt,
    input  logic [133:0] in_rpt_data_0,
    input  logic [133:0] in_rpt_data_1,
    input  logic [133:0] in_rpt_data_2,
    input  logic         in_rpt_data_wr_0,
    input  logic         in_rpt_data_wr_1,
    input  logic         in_rpt_data_wr_2,
    input  logic         in_rpt_data_valid_0,
    input  logic         in_rpt_data_valid_1,
    input  logic         in_rpt_data_valid_2,
    input  logic         in_rpt_data_valid_wr_0,
    input  logic         in_rpt_data_valid_wr_1,
    input  logic         in_rpt_data_valid_wr_2,
    output logic [133:0] out_arm_data,
    output logic         out_arm_data_wr,
    output logic         out_arm_data_valid,
    output logic         out_arm_data_valid_wr,
    output logic [15:0]  out_rpt_timeout_cnt
);

    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    state_t       state, state_nxt;
    logic [1:0]   rr_ptr, rr_ptr_nxt;
    logic [1:0]   gnt_idx, gnt_idx_nxt, pick_idx;
    logic [2:0]   gnt_nxt;
    logic [133:0] sel_data, data_nxt;
    logic         sel_wr, sel_vld, sel_vld_wr;
    logic         wr_nxt, vld_nxt, vld_wr_nxt;

    // PLATFORM only tags the vendor; it has no functional effect.
    logic unused_platform;
    assign unused_platform = (PLATFORM == "");

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Steer the currently granted source onto the internal select bus.
    always_comb begin
        sel_data   = '0;
        sel_wr     = 1'b0;
        sel_vld    = 1'b0;
        sel_vld_wr = 1'b0;
        case (gnt_idx)
            2'd0: begin
                sel_data = in_rpt_data_0; sel_wr = in_rpt_data_wr_0;
                sel_vld = in_rpt_data_valid_0; sel_vld_wr = in_rpt_data_valid_wr_0;
            end
            2'd1: begin
                sel_data = in_rpt_data_1; sel_wr = in_rpt_data_wr_1;
                sel_vld = in_rpt_data_valid_1; sel_vld_wr = in_rpt_data_valid_wr_1;
            end
            2'd2: begin
                sel_data = in_rpt_data_2; sel_wr = in_rpt_data_wr_2;
                sel_vld = in_rpt_data_valid_2; sel_vld_wr = in_rpt_data_valid_wr_2;
            end
            default: ;
        endcase
    end

    // First requester at or after rr_ptr in circular order 0,1,2.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        cand     = rr_ptr;
        found    = 1'b0;
        pick_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!found && in_rpt_req[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
            cand = next_idx(cand);
        end
    end

`ifdef REPORT_ARB_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic [15:0] to_cnt;
    logic        wd_hit;

    // Fires on the TIMEOUT_CYCLES-th cycle spent holding a grant.
    assign wd_hit = (state != IDLE) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared while idle (hence on every new grant), counts while granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 wd_cnt <= '0;
        else if (state == IDLE)  wd_cnt <= '0;
        else                     wd_cnt <= wd_cnt + 32'd1;
    end

    // Saturating count of watchdog-terminated packets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               to_cnt <= '0;
        else if (wd_hit && to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
    end

    assign out_rpt_timeout_cnt = to_cnt;
`else
    logic unused_timeout;
    assign unused_timeout      = (TIMEOUT_CYCLES == 0);
    assign out_rpt_timeout_cnt = '0;
`endif

    // Next-state and next-output decode; all outputs idle to zero by default.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = out_rpt_gnt;
        gnt_idx_nxt = gnt_idx;
        rr_ptr_nxt  = rr_ptr;
        data_nxt    = '0;
        wr_nxt      = 1'b0;
        vld_nxt     = 1'b0;
        vld_wr_nxt  = 1'b0;
        case (state)
            IDLE: if (|in_rpt_req) begin
                gnt_idx_nxt = pick_idx;
                gnt_nxt     = 3'b001 << pick_idx;
                state_nxt   = GRANT;
            end
            // Wait for a proper head; anything else from the granted source is dropped.
            GRANT: if (sel_wr && sel_data[133:132] == 2'b01) begin
                data_nxt  = sel_data;
                wr_nxt    = 1'b1;
                state_nxt = XFER;
            end
            XFER: begin
                if (sel_wr) begin
                    data_nxt = sel_data;
                    wr_nxt   = 1'b1;
                end
                if (sel_vld_wr) begin
                    vld_nxt    = sel_vld;
                    vld_wr_nxt = 1'b1;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = next_idx(gnt_idx);
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef REPORT_ARB_TIMEOUT_EN
        // Watchdog overrides whatever the source is doing this cycle.
        if (wd_hit) begin
            data_nxt   = '0;
            wr_nxt     = 1'b0;
            vld_nxt    = 1'b0;
            vld_wr_nxt = 1'b0;
            if (state == XFER) begin
                data_nxt   = {2'b10, 4'd0, 128'd0};
                wr_nxt     = 1'b1;
                vld_wr_nxt = 1'b1;
            end
            gnt_nxt    = '0;
            rr_ptr_nxt = next_idx(gnt_idx);
            state_nxt  = IDLE;
        end
`endif
    end

    // State, arbitration pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            rr_ptr                <= 2'd0;
            gnt_idx               <= 2'd0;
            out_rpt_gnt           <= '0;
            out_arm_data          <= '0;
            out_arm_data_wr       <= 1'b0;
            out_arm_data_valid    <= 1'b0;
            out_arm_data_valid_wr <= 1'b0;
        end else begin
            state                 <= state_nxt;
            rr_ptr                <= rr_ptr_nxt;
            gnt_idx               <= gnt_idx_nxt;
            out_rpt_gnt           <= gnt_nxt;
            out_arm_data          <= data_nxt;
            out_arm_data_wr       <= wr_nxt;
            out_arm_data_valid    <= vld_nxt;
            out_arm_data_valid_wr <= vld_wr_nxt;
        end
    end

endmodule

// File: tb/tb_report_arb.sv
// tb_report_arb: randomized packet sources with a queue-based reference model
// of the merged stream (beat order, timing, valid flags and grant order).
`timescale 1ns/1ps
module tb_report_arb;

    localparam int TO = 16;
`ifdef REPORT_ARB_TIMEOUT_EN
    localparam int LEN_SINGLE = 8;
    localparam bit STALL_OK   = 1'b0;
`else
    localparam int LEN_SINGLE = 37;
    localparam bit STALL_OK   = 1'b1;
`endif

    typedef struct {int len; bit v; bit bad; bit stall;} pkt_t;
    typedef struct {logic [133:0] d; int c;} exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req = '0;
    logic [2:0]   gnt;
    logic [133:0] dat [3];
    logic [2:0]   wr = '0, vld = '0, vwr = '0;
    logic [133:0] out_data;
    logic         out_wr, out_vld, out_vwr;
    logic [15:0]  to_cnt;

    int   n_chk = 0, n_err = 0, cyc = 0, mptr = 0, last_vwr = -10;
    pkt_t pend [3][$];
    int   bi [3];
    int   gcyc [3];
    bit   rogue [3];
    logic [2:0] prev_gnt = '0, prev_req = '0;
    exp_t exp_b [$];
    exp_t exp_v [$];
    int   glog [$];

    report_arb #(.PLATFORM("xilinx"), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_rpt_req(req), .out_rpt_gnt(gnt),
        .in_rpt_data_0(dat[0]), .in_rpt_data_1(dat[1]), .in_rpt_data_2(dat[2]),
        .in_rpt_data_wr_0(wr[0]), .in_rpt_data_wr_1(wr[1]), .in_rpt_data_wr_2(wr[2]),
        .in_rpt_data_valid_0(vld[0]), .in_rpt_data_valid_1(vld[1]), .in_rpt_data_valid_2(vld[2]),
        .in_rpt_data_valid_wr_0(vwr[0]), .in_rpt_data_valid_wr_1(vwr[1]),
        .in_rpt_data_valid_wr_2(vwr[2]),
        .out_arm_data(out_data), .out_arm_data_wr(out_wr),
        .out_arm_data_valid(out_vld), .out_arm_data_valid_wr(out_vwr),
        .out_rpt_timeout_cnt(to_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] want);
        n_chk++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, want, cyc);
        end
    endtask

    function automatic logic [133:0] mk_beat(input logic [1:0] typ);
        logic [133:0] b;
        b[127:0]   = {$urandom, $urandom, $urandom, $urandom};
        b[131:128] = 4'($urandom_range(15));
        b[133:132] = typ;
        return b;
    endfunction

    // Reference round-robin: first requester at or after the model pointer.
    task automatic on_grant(input logic [2:0] g);
        int want = -1;
        int got  = 0;
        logic [2:0] wg;
        for (int k = 0; k < 3; k++)
            if (want < 0 && prev_req[(mptr + k) % 3]) want = (mptr + k) % 3;
        for (int k = 0; k < 3; k++)
            if (g[k]) got = k;
        wg = (want < 0) ? 3'b000 : 3'(1 << want);
        chk("gnt_pick", 134'(g), 134'(wg));
        glog.push_back(got);
        gcyc[got] = cyc;
    endtask

    // One clock of source behaviour; inputs change 1ns after the rising edge.
    task automatic tick();
        logic [2:0] g;
        pkt_t p;
        int k;
        @(posedge clk);
        #1;
        cyc++;
        g = gnt;
        if (g != 3'b000 && prev_gnt == 3'b000) on_grant(g);
        prev_gnt = g;
        for (int s = 0; s < 3; s++) begin
            wr[s] = 1'b0; vwr[s] = 1'b0; vld[s] = 1'b0; dat[s] = '0;
            if (!g[s] && bi[s] > 0) begin
                // Grant withdrawn mid-packet (watchdog): abandon it.
                void'(pend[s].pop_front());
                bi[s] = 0;
                mptr  = (s + 1) % 3;
            end
            if (g[s] && pend[s].size() > 0) begin
                p = pend[s][0];
                k = bi[s] - (p.bad ? 1 : 0);
                if (STALL_OK && $urandom_range(3) == 0) begin
                end else if (p.stall && k > 0) begin
                end else begin
                    wr[s] = 1'b1;
                    if (p.bad && bi[s] == 0) begin
                        dat[s] = mk_beat(2'b11);
                    end else begin
                        dat[s] = mk_beat(k == 0 ? 2'b01 : (k == p.len - 1 ? 2'b10 : 2'b11));
                        exp_b.push_back('{dat[s], cyc + 1});
                        if (k == 0 && p.stall) begin
                            exp_b.push_back('{{2'b10, 132'd0}, gcyc[s] + TO});
                            exp_v.push_back('{134'd0, gcyc[s] + TO});
                        end
                    end
                    bi[s]++;
                    if (k == p.len - 1) begin
                        vwr[s] = 1'b1;
                        vld[s] = p.v;
                        exp_v.push_back('{134'(p.v), cyc + 1});
                        void'(pend[s].pop_front());
                        bi[s] = 0;
                        mptr  = (s + 1) % 3;
                    end
                end
            end else if (!g[s] && rogue[s]) begin
                wr[s]  = 1'b1;
                dat[s] = mk_beat(2'($urandom_range(3)));
                vwr[s] = 1'($urandom_range(1));
                vld[s] = 1'b1;
            end
            // Requests may drop while granted; the grant must stay.
            req[s] = (pend[s].size() > 0) && !(g[s] && $urandom_range(1) == 1);
        end
        prev_req = req;
    endtask

    function automatic bit busy();
        return pend[0].size() > 0 || pend[1].size() > 0 || pend[2].size() > 0 ||
               exp_b.size() > 0 || exp_v.size() > 0 || gnt != 3'b000;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 134'(busy()), 134'd0);
        repeat (2) tick();
        chk({tag, "_gnt0"}, 134'(gnt), 134'd0);
    endtask

    // Output monitor: compare every merged beat / valid strobe against the model.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (out_wr) begin
                if (exp_b.size() == 0) chk("unexp_beat", 134'd1, 134'd0);
                else begin
                    e = exp_b.pop_front();
                    chk("beat", out_data, e.d);
                    chk("beat_cyc", 134'(cyc), 134'(e.c));
                end
                if (out_data[133:132] == 2'b01) chk("idle_gap", 134'(cyc - last_vwr >= 2), 134'd1);
            end else chk("data_zero", out_data, 134'd0);
            if (out_vwr) begin
                if (exp_v.size() == 0) chk("unexp_vwr", 134'd1, 134'd0);
                else begin
                    e = exp_v.pop_front();
                    chk("valid", 134'(out_vld), e.d);
                    chk("valid_cyc", 134'(cyc), 134'(e.c));
                end
                last_vwr = cyc;
            end else chk("valid_zero", 134'(out_vld), 134'd0);
            chk("gnt_onehot", 134'($onehot0(gnt)), 134'd1);
        end
    end

    initial begin
        int n;
        for (int s = 0; s < 3; s++) begin
            dat[s] = '0; bi[s] = 0; rogue[s] = 1'b0; gcyc[s] = 0;
        end
        repeat (3) tick();
        chk("rst_gnt", 134'(gnt), 134'd0);
        chk("rst_data", out_data, 134'd0);
        chk("rst_flags", 134'({out_wr, out_vld, out_vwr}), 134'd0);
        chk("rst_tocnt", 134'(to_cnt), 134'd0);
        rst = 1'b0;
        tick();

        // Round-robin: everyone requests, 3-beat packets.
        glog.delete();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) pend[s].push_back('{3, 1'($urandom_range(1)), 1'b0, 1'b0});
        wait_idle("rr", 400);
        chk("rr_n", 134'(glog.size()), 134'd6);
        for (int i = 0; i < 4; i++)
            chk("rr_order", 134'(glog.size() > i ? glog[i] : -1), 134'(i % 3));

        // Single long packet from source 0.
        glog.delete();
        pend[0].push_back('{LEN_SINGLE, 1'b1, 1'b0, 1'b0});
        wait_idle("single", 400);
        chk("single_gnt", 134'(glog.size() > 0 ? glog[0] : -1), 134'd0);

        // Isolation: source 1 scribbles while source 0 holds the grant.
        rogue[1] = 1'b1;
        pend[0].push_back('{LEN_SINGLE > 10 ? 10 : LEN_SINGLE, 1'b1, 1'b0, 1'b0});
        wait_idle("iso", 400);
        rogue[1] = 1'b0;

        // Bad head dropped.
        pend[1].push_back('{6, 1'b1, 1'b1, 1'b0});
        wait_idle("badhead", 200);

        // Random mix.
        for (int i = 0; i < 8; i++)
            pend[$urandom_range(2)].push_back('{int'($urandom_range(2, 8)), 1'($urandom_range(1)),
                                                 $urandom_range(3) == 0, 1'b0});
        wait_idle("mix", 1000);

`ifdef REPORT_ARB_TIMEOUT_EN
        // Watchdog: source 2 sends a head and stalls.
        pend[2].push_back('{6, 1'b1, 1'b0, 1'b1});
        n = 0;
        while (gnt == 3'b000 && n < 50) begin tick(); n++; end
        chk("wd_gnt2", 134'(gnt), 134'(3'b100));
        glog.delete();
        pend[0].push_back('{3, 1'b1, 1'b0, 1'b0});
        pend[1].push_back('{3, 1'b1, 1'b0, 1'b0});
        wait_idle("wd", 300);
        chk("wd_next", 134'(glog.size() > 0 ? glog[0] : -1), 134'd0);
        chk("wd_tocnt", 134'(to_cnt), 134'd1);
`else
        chk("tocnt_tied", 134'(to_cnt), 134'd0);
`endif

        // Reset mid-packet.
        pend[0].push_back('{12, 1'b1, 1'b0, 1'b0});
        n = 0;
        while (bi[0] < 5 && n < 200) begin tick(); n++; end
        chk("rst_reach", 134'(bi[0] >= 5), 134'd1);
        #2 rst = 1'b1;
        #1;
        chk("mrst_gnt", 134'(gnt), 134'd0);
        chk("mrst_data", out_data, 134'd0);
        chk("mrst_flags", 134'({out_wr, out_vld, out_vwr}), 134'd0);
        for (int s = 0; s < 3; s++) begin
            pend[s].delete(); bi[s] = 0;
        end
        req = '0; wr = '0; vwr = '0; vld = '0;
        exp_b.delete(); exp_v.delete();
        mptr = 0; prev_gnt = '0; prev_req = '0;
        repeat (2) tick();
        rst = 1'b0;
        glog.delete();
        pend[1].push_back('{4, 1'b1, 1'b0, 1'b0});
        wait_idle("postrst", 200);
        chk("postrst_gnt", 134'(glog.size() > 0 ? glog[0] : -1), 134'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/report_arb.md
REPORT_ARB -- requirements
Module: report_arb

Interface
REQ-001 Parameter PLATFORM, default "xilinx", selects the target vendor; no functional effect.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, sets the watchdog limit in cycles per granted packet.
REQ-003 Port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_rpt_req  input  3  per-source packet request; bit i belongs to source i.
REQ-006 Port out_rpt_gnt  output  3  one-hot grant; all zero when idle.
REQ-007 Port in_rpt_data_0/1/2  input  134  per-source packet beat: [133:132] 01=head, 11=body, 10=tail; [131:128] valid-byte count.
REQ-008 Port in_rpt_data_wr_0/1/2  input  1  per-source beat strobe.
REQ-009 Port in_rpt_data_valid_0/1/2  input  1  per-source packet-valid flag, qualified by the valid strobe.
REQ-010 Port in_rpt_data_valid_wr_0/1/2  input  1  per-source packet-valid strobe, coincident with the tail beat.
REQ-011 Port out_arm_data  output  134  merged beat toward the FPGA OS.
REQ-012 Port out_arm_data_wr  output  1  merged beat strobe.
REQ-013 Port out_arm_data_valid  output  1  merged packet-valid flag.
REQ-014 Port out_arm_data_valid_wr  output  1  merged packet-valid strobe.
REQ-015 Port out_rpt_timeout_cnt  output  16  saturating count of watchdog-terminated packets.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT and XFER.
REQ-017 In IDLE with any in_rpt_req bit set, the block SHALL grant the first requester at or after rr_ptr (circular order 0,1,2), assert out_rpt_gnt one cycle later and enter GRANT.
REQ-018 In GRANT, the granted source's data_wr beat with [133:132]=01 SHALL be forwarded and the FSM SHALL enter XFER.
REQ-019 In GRANT, a granted-source beat whose [133:132] is not 01 SHALL be discarded without output.
REQ-020 In XFER, every data_wr beat of the granted source SHALL be forwarded unchanged.
REQ-021 Forwarded outputs SHALL be registered with exactly 1 cycle of latency; beats from non-granted sources SHALL be ignored.
REQ-022 On the granted source's data_valid_wr, the valid flag and strobe SHALL be forwarded with the same 1-cycle latency.
REQ-023 After the granted source's data_valid_wr, the grant SHALL be released the next cycle, rr_ptr SHALL be set to the granted index+1 modulo 3 (2 wraps to 0), and the FSM SHALL return to IDLE.
REQ-024 A new grant SHALL NOT be issued before the cycle after release, giving a minimum of one idle output cycle between packets.
REQ-025 Deassertion of in_rpt_req during GRANT or XFER SHALL NOT revoke the grant.
REQ-026 When out_arm_data_wr is not asserted, out_arm_data SHALL be driven to 0.
REQ-027 When out_arm_data_valid_wr is not asserted, out_arm_data_valid SHALL be driven to 0.

Reset
REQ-028 While rst is high, all outputs SHALL be 0, the FSM SHALL be in IDLE, rr_ptr SHALL be 0 and the watchdog counter SHALL be 0.
REQ-029 Reset asserted mid-packet SHALL abort the packet with no tail emitted; after release, the first grant SHALL follow REQ-017.

Configuration
REQ-030 With macro REPORT_ARB_TIMEOUT_EN defined, a watchdog SHALL count cycles in GRANT or XFER and reset to 0 on every grant.
REQ-031 With REPORT_ARB_TIMEOUT_EN defined, when the watchdog reaches TIMEOUT_CYCLES the block SHALL take the following action.
- In XFER, emit tail beat {2'b10,4'd0,128'd0} together with out_arm_data_valid=0 and out_arm_data_valid_wr=1.
- In GRANT, emit nothing.
- In both cases, increment out_rpt_timeout_cnt (saturating at 16'hFFFF), release the grant and advance rr_ptr as in REQ-023.
REQ-032 Without REPORT_ARB_TIMEOUT_EN, no watchdog logic SHALL exist, the grant SHALL be held until data_valid_wr, and out_rpt_timeout_cnt SHALL be tied to 0.

Verification
REQ-033 Single source: source 0 requests and sends a 37-beat packet ending with valid=1 -> gnt=001; output equals the input delayed 1 cycle; one valid_wr with valid=1; gnt=000 afterwards.
REQ-034 Round-robin: all three sources request continuously, each sending 3-beat packets -> grant order 0,1,2,0; at least one idle cycle between output packets; no interleaved beats.
REQ-035 Isolation: source 1 drives data_wr beats while source 0 holds the grant -> none of source 1's beats appear on the output.
REQ-036 Bad head: the granted source's first beat has [133:132]=11, followed by a proper 01 head -> the first beat is dropped and the packet starts at the 01 beat.
REQ-037 Watchdog (macro on, TIMEOUT_CYCLES=16): source 2 sends its head then stalls -> forced tail 10 with valid_wr=1 and valid=0; timeout_cnt=1; next grant goes to source 0.
REQ-038 Reset mid-packet: rst pulsed during XFER of beat 5 -> all outputs 0 immediately; after release, a request from source 1 alone is granted first.
